// File: rtl/vm_pkg.sv
// Shared types and helpers for the N-candidate voting controller.
// State encoding is visible on the state port, so the values are fixed here.
package vm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPEN    = 3'd1,
        ST_LOCKOUT = 3'd2,
        ST_TALLY   = 3'd3,
        ST_DONE    = 3'd4
    } vm_state_e;

    function automatic int cidx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/vm_pulse_timer.sv
// Reloadable down-counter: active while non-zero, last on its final active cycle.
// A load always restarts the full CYCLES count, even while already running.
module vm_pulse_timer #(
    parameter int CYCLES = 1,
    parameter int W      = $clog2(CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic active,
    output logic last
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= W'(CYCLES);
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign active = (count != '0);
    assign last   = (count == W'(1));

endmodule

// File: rtl/voting_machine_n.sv
// Session-based N-candidate voting controller with saturating tallies,
// post-vote lockout, per-candidate LED pulses and a sequential winner scan.
module voting_machine_n
    import vm_pkg::*;
#(
    parameter int  NUM_CAND       = 4,
    parameter int  CNT_W          = 8,
    parameter int  LED_CYCLES     = 5,
    parameter int  LOCKOUT_CYCLES = 16,
    localparam int CIDX_W         = cidx_w(NUM_CAND)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      session_open,
    input  logic                      session_close,
    input  logic                      vote_valid,
    input  logic [NUM_CAND-1:0]       vote_sel,
    output logic                      vote_ready,
    output logic                      vote_reject,
    output logic [NUM_CAND-1:0]       leds,
    output logic [NUM_CAND*CNT_W-1:0] counts,
    output logic [CNT_W-1:0]          total_votes,
    output logic [CNT_W-1:0]          reject_cnt,
    output logic [2:0]                state,
    output logic                      result_valid,
    output logic [CIDX_W-1:0]         winner_idx,
    output logic                      winner_tie
);

    vm_state_e           cur_state, nxt_state;
    logic [CNT_W-1:0]    tally [NUM_CAND];
    logic                accept, reject, clear_session, scan_last;
    logic                lock_active, lock_last;
    logic [NUM_CAND-1:0] unused_led_last;
    logic [CIDX_W-1:0]   scan_idx, max_idx, cmp_idx;
    logic [CNT_W-1:0]    max_val, cmp_max, cmp_val;
    logic                max_tie, cmp_tie;

    assign accept        = (cur_state == ST_OPEN) && vote_valid && $onehot(vote_sel);
    assign reject        = (cur_state == ST_OPEN) && vote_valid && !$onehot(vote_sel);
    assign clear_session = ((cur_state == ST_IDLE) || (cur_state == ST_DONE)) && session_open;
    assign scan_last     = (cur_state == ST_TALLY) && (scan_idx == CIDX_W'(NUM_CAND - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Close wins over the lockout return, so a vote taken with close goes straight to TALLY.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_IDLE, ST_DONE: if (session_open) nxt_state = ST_OPEN;
            ST_OPEN: begin
                if (session_close)  nxt_state = ST_TALLY;
                else if (accept)    nxt_state = ST_LOCKOUT;
            end
            ST_LOCKOUT: begin
                if (session_close)                  nxt_state = ST_TALLY;
                else if (lock_last || !lock_active) nxt_state = ST_OPEN;
            end
            ST_TALLY: if (scan_last) nxt_state = ST_DONE;
            default:  nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        vote_ready   = (cur_state == ST_OPEN);
        result_valid = (cur_state == ST_DONE);
        state        = cur_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
            total_votes <= '0;
            reject_cnt  <= '0;
            vote_reject <= 1'b0;
        end else begin
            vote_reject <= reject;
            if (clear_session) begin
                for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
                total_votes <= '0;
                reject_cnt  <= '0;
            end else begin
                if (accept) begin
                    for (int i = 0; i < NUM_CAND; i++) begin
                        if (vote_sel[i]) tally[i] <= CNT_W'(sat_inc(32'(tally[i]), CNT_W));
                    end
                    total_votes <= CNT_W'(sat_inc(32'(total_votes), CNT_W));
                end
                if (reject) reject_cnt <= CNT_W'(sat_inc(32'(reject_cnt), CNT_W));
            end
        end
    end

    always_comb begin
        counts = '0;
        for (int i = 0; i < NUM_CAND; i++) counts[i*CNT_W +: CNT_W] = tally[i];
    end

    // Running max starts at zero, so an all-zero ballot box ends as a tie at index 0.
    always_comb begin
        cmp_val = tally[scan_idx];
        cmp_max = max_val;
        cmp_idx = max_idx;
        cmp_tie = max_tie;
        if (cmp_val > max_val) begin
            cmp_max = cmp_val;
            cmp_idx = scan_idx;
            cmp_tie = 1'b0;
        end else if (cmp_val == max_val) begin
            cmp_tie = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_idx   <= '0;
            max_val    <= '0;
            max_idx    <= '0;
            max_tie    <= 1'b0;
            winner_idx <= '0;
            winner_tie <= 1'b0;
        end else begin
            if (cur_state == ST_TALLY) begin
                scan_idx <= scan_idx + CIDX_W'(1);
                max_val  <= cmp_max;
                max_idx  <= cmp_idx;
                max_tie  <= cmp_tie;
            end else begin
                scan_idx <= '0;
                max_val  <= '0;
                max_idx  <= '0;
                max_tie  <= 1'b0;
            end
            if (scan_last) begin
                winner_idx <= cmp_idx;
                winner_tie <= cmp_tie;
            end else if (clear_session) begin
                winner_idx <= '0;
                winner_tie <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_led
        vm_pulse_timer #(
            .CYCLES (LED_CYCLES),
            .W      ($clog2(LED_CYCLES + 1))
        ) u_led (
            .clk    (clk),
            .reset  (reset),
            .load   (accept && vote_sel[g]),
            .active (leds[g]),
            .last   (unused_led_last[g])
        );
    end

    vm_pulse_timer #(
        .CYCLES (LOCKOUT_CYCLES),
        .W      ($clog2(LOCKOUT_CYCLES + 1))
    ) u_lockout (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .active (lock_active),
        .last   (lock_last)
    );

endmodule

// File: tb/tb_voting_machine_n.sv
// Directed bench for voting_machine_n: a session-level reference model checked
// every cycle, plus hand-computed expectations at the key points.
module tb_voting_machine_n;
    import vm_pkg::*;

    localparam int NC    = 4;
    localparam int CW    = 8;
    localparam int LEDC  = 5;
    localparam int LOCKC = 16;
    localparam int MAXV  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          session_open = 1'b0;
    logic          session_close = 1'b0;
    logic          vote_valid = 1'b0;
    logic [NC-1:0] vote_sel = '0;
    logic          vote_ready, vote_reject, result_valid, winner_tie;
    logic [NC-1:0] leds;
    logic [NC*CW-1:0] counts;
    logic [CW-1:0] total_votes, reject_cnt;
    logic [2:0]    state;
    logic [1:0]    winner_idx;

    int total_cmp = 0;
    int bad_cmp   = 0;

    vm_state_e m_state = ST_IDLE;
    int m_counts [NC] = '{default: 0};
    int m_led    [NC] = '{default: 0};
    int m_total = 0, m_reject = 0, m_rej = 0, m_lock = 0, m_left = 0, m_winner = 0, m_tie = 0;

    always #5 clk = ~clk;

    voting_machine_n #(
        .NUM_CAND       (NC),
        .CNT_W          (CW),
        .LED_CYCLES     (LEDC),
        .LOCKOUT_CYCLES (LOCKC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .session_open  (session_open),
        .session_close (session_close),
        .vote_valid    (vote_valid),
        .vote_sel      (vote_sel),
        .vote_ready    (vote_ready),
        .vote_reject   (vote_reject),
        .leds          (leds),
        .counts        (counts),
        .total_votes   (total_votes),
        .reject_cnt    (reject_cnt),
        .state         (state),
        .result_valid  (result_valid),
        .winner_idx    (winner_idx),
        .winner_tie    (winner_tie)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cmp++;
        if (actual !== expected) begin
            bad_cmp++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Session-level reference model stepped on every clock edge.
    initial forever begin : model
        bit acc, rej;
        int best, nbest;
        @(posedge clk or posedge reset);
        if (reset) begin
            m_state = ST_IDLE;
            for (int i = 0; i < NC; i++) begin
                m_counts[i] = 0;
                m_led[i] = 0;
            end
            m_total = 0; m_reject = 0; m_rej = 0; m_lock = 0; m_left = 0; m_winner = 0; m_tie = 0;
        end else begin
            acc = (m_state == ST_OPEN) && vote_valid && ($countones(vote_sel) == 1);
            rej = (m_state == ST_OPEN) && vote_valid && ($countones(vote_sel) != 1);
            m_rej = rej;
            for (int i = 0; i < NC; i++) if (m_led[i] > 0) m_led[i]--;
            case (m_state)
                ST_IDLE, ST_DONE: begin
                    if (session_open) begin
                        for (int i = 0; i < NC; i++) m_counts[i] = 0;
                        m_total = 0; m_reject = 0; m_winner = 0; m_tie = 0;
                        m_state = ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    if (acc) begin
                        for (int i = 0; i < NC; i++) begin
                            if (vote_sel[i]) begin
                                m_counts[i] = (m_counts[i] < MAXV) ? m_counts[i] + 1 : MAXV;
                                m_led[i] = LEDC;
                            end
                        end
                        m_total = (m_total < MAXV) ? m_total + 1 : MAXV;
                        m_lock = LOCKC;
                        m_state = ST_LOCKOUT;
                    end
                    if (rej) m_reject = (m_reject < MAXV) ? m_reject + 1 : MAXV;
                    if (session_close) begin
                        m_state = ST_TALLY;
                        m_left = NC;
                    end
                end
                ST_LOCKOUT: begin
                    m_lock--;
                    if (session_close) begin
                        m_state = ST_TALLY;
                        m_left = NC;
                    end else if (m_lock == 0) begin
                        m_state = ST_OPEN;
                    end
                end
                ST_TALLY: begin
                    m_left--;
                    if (m_left == 0) begin
                        best = -1;
                        for (int i = 0; i < NC; i++) begin
                            if (m_counts[i] > best) begin
                                best = m_counts[i];
                                m_winner = i;
                            end
                        end
                        nbest = 0;
                        for (int i = 0; i < NC; i++) if (m_counts[i] == best) nbest++;
                        m_tie = (nbest > 1);
                        m_state = ST_DONE;
                    end
                end
                default: m_state = ST_IDLE;
            endcase
        end
    end

    initial forever begin : compare
        logic [NC*CW-1:0] exp_counts;
        logic [NC-1:0]    exp_leds;
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            exp_counts[i*CW +: CW] = CW'(m_counts[i]);
            exp_leds[i] = (m_led[i] > 0);
        end
        check_output("state", 32'(state), 32'(m_state));
        check_output("vote_ready", 32'(vote_ready), 32'(m_state == ST_OPEN));
        check_output("vote_reject", 32'(vote_reject), 32'(m_rej));
        check_output("leds", 32'(leds), 32'(exp_leds));
        check_output("counts", 32'(counts), 32'(exp_counts));
        check_output("total_votes", 32'(total_votes), 32'(m_total));
        check_output("reject_cnt", 32'(reject_cnt), 32'(m_reject));
        check_output("result_valid", 32'(result_valid), 32'(m_state == ST_DONE));
        check_output("winner_idx", 32'(winner_idx), 32'(m_winner));
        check_output("winner_tie", 32'(winner_tie), 32'(m_tie));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!vote_ready && n < 60) begin
            tick();
            n++;
        end
        if (!vote_ready) check_output("ready_timeout", 32'(vote_ready), 32'd1);
    endtask

    task automatic apply_stimulus(input logic [NC-1:0] sel, input logic close);
        wait_ready();
        vote_valid = 1'b1;
        vote_sel = sel;
        session_close = close;
        tick();
        vote_valid = 1'b0;
        vote_sel = '0;
        session_close = 1'b0;
    endtask

    task automatic open_session();
        session_open = 1'b1;
        tick();
        session_open = 1'b0;
    endtask

    task automatic close_session();
        session_close = 1'b1;
        tick();
        session_close = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!result_valid && n < 40) begin
            tick();
            n++;
        end
        if (!result_valid) check_output("done_timeout", 32'(result_valid), 32'd1);
    endtask

    initial begin : stimulus
        int low_cycles, led_cycles, scan_cycles;
        tick();
        tick();
        check_output("reset_state", 32'(state), 32'(ST_IDLE));
        check_output("reset_counts", 32'(counts), 32'h0);
        reset = 1'b0;
        tick();

        open_session();
        check_output("open_state", 32'(state), 32'(ST_OPEN));
        apply_stimulus(4'b0100, 1'b0);
        check_output("first_counts", 32'(counts), 32'h0001_0000);
        check_output("first_total", 32'(total_votes), 32'd1);
        check_output("first_state", 32'(state), 32'(ST_LOCKOUT));

        // Count lockout and LED length; poke vote_valid mid-lockout, which must be ignored.
        low_cycles = 0;
        led_cycles = 0;
        while (!vote_ready && low_cycles < 40) begin
            if (leds[2]) led_cycles++;
            vote_valid = (low_cycles >= 3 && low_cycles < 6);
            vote_sel = 4'b0001;
            low_cycles++;
            tick();
        end
        vote_valid = 1'b0;
        vote_sel = '0;
        check_output("lockout_len", 32'(low_cycles), 32'd16);
        check_output("led_len", 32'(led_cycles), 32'd5);
        check_output("lockout_ignored_counts", 32'(counts), 32'h0001_0000);
        check_output("lockout_no_reject", 32'(reject_cnt), 32'd0);

        apply_stimulus(4'b0110, 1'b0);
        check_output("reject_pulse", 32'(vote_reject), 32'd1);
        check_output("reject_cnt", 32'(reject_cnt), 32'd1);
        check_output("reject_state", 32'(state), 32'(ST_OPEN));
        tick();
        check_output("reject_pulse_end", 32'(vote_reject), 32'd0);
        apply_stimulus(4'b0000, 1'b0);
        check_output("zero_hot_reject", 32'(reject_cnt), 32'd2);

        apply_stimulus(4'b0010, 1'b1);
        check_output("close_vote_counts", 32'(counts), 32'h0001_0100);
        check_output("close_state", 32'(state), 32'(ST_TALLY));
        wait_done(scan_cycles);
        check_output("scan_cycles", 32'(scan_cycles), 32'd4);
        check_output("s1_winner", 32'(winner_idx), 32'd1);
        check_output("s1_tie", 32'(winner_tie), 32'd1);

        open_session();
        check_output("s2_cleared", 32'(counts), 32'h0);
        check_output("s2_result_low", 32'(result_valid), 32'd0);
        for (int k = 0; k < 3; k++) apply_stimulus(4'b0001, 1'b0);
        for (int k = 0; k < 3; k++) apply_stimulus(4'b0010, 1'b0);
        apply_stimulus(4'b0100, 1'b0);
        close_session();
        wait_done(scan_cycles);
        check_output("s2_counts", 32'(counts), 32'h0001_0303);
        check_output("s2_winner", 32'(winner_idx), 32'd0);
        check_output("s2_tie", 32'(winner_tie), 32'd1);

        open_session();
        apply_stimulus(4'b1000, 1'b0);
        apply_stimulus(4'b1000, 1'b0);
        apply_stimulus(4'b0010, 1'b0);
        close_session();
        wait_done(scan_cycles);
        check_output("s3_winner", 32'(winner_idx), 32'd3);
        check_output("s3_tie", 32'(winner_tie), 32'd0);

        open_session();
        close_session();
        wait_done(scan_cycles);
        check_output("s4_zero_winner", 32'(winner_idx), 32'd0);
        check_output("s4_zero_tie", 32'(winner_tie), 32'd1);

        open_session();
        for (int k = 0; k < MAXV + 3; k++) apply_stimulus(4'b1000, 1'b0);
        check_output("sat_counts", 32'(counts), 32'hFF00_0000);
        check_output("sat_total", 32'(total_votes), 32'd255);
        check_output("sat_still_locks", 32'(state), 32'(ST_LOCKOUT));

        // Asynchronous reset in the middle of a lockout, away from any clock edge.
        #2;
        reset = 1'b1;
        #1;
        check_output("areset_state", 32'(state), 32'(ST_IDLE));
        check_output("areset_counts", 32'(counts), 32'h0);
        check_output("areset_total", 32'(total_votes), 32'd0);
        check_output("areset_leds", 32'(leds), 32'd0);
        check_output("areset_ready", 32'(vote_ready), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total_cmp, bad_cmp);
        $finish;
    end

endmodule
